// File: rtl/mcb_result_writer.sv
// mcb_result_writer: pairs consecutive MC_A samples as (x, y) and writes
// (x >= y) ? x-y : x+y into MC_B through WEB/AddrB/DataInB, 2**ADDR_W
// results per batch, then pulses done.
// Optional feature: define MCB_SATURATE_EN to clamp an overflowing x+y to
// all-ones instead of wrapping (ovf is set either way).
module mcb_result_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              WEB,
  output logic [ADDR_W-1:0] AddrB,
  output logic [DATA_W-1:0] DataInB,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    SECOND = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e              state_q;
  logic                in_ready_q;
  logic                web_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [DATA_W-1:0]   x_q;

  logic [DATA_W:0]     sum_d;
  logic [DATA_W-1:0]   diff_d;
  logic                ge_d;
  logic                carry_d;
  logic [DATA_W-1:0]   add_res_d;
  logic [DATA_W-1:0]   result_d;

  // Datapath for the pair (x_q, in_data): compare, then subtract or add.
  always_comb begin
    sum_d   = {1'b0, x_q} + {1'b0, in_data};
    diff_d  = x_q - in_data;
    ge_d    = (x_q >= in_data);
    carry_d = ~ge_d & sum_d[DATA_W];
`ifdef MCB_SATURATE_EN
    add_res_d = carry_d ? '1 : sum_d[DATA_W-1:0];
`else
    add_res_d = sum_d[DATA_W-1:0];
`endif
    result_d = ge_d ? diff_d : add_res_d;
  end

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      web_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      x_q        <= '0;
    end else begin
      web_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= FIRST;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FIRST: begin
          if (in_valid && in_ready_q) begin
            x_q     <= in_data;
            state_q <= SECOND;
          end
        end
        SECOND: begin
          if (in_valid && in_ready_q) begin
            data_q     <= result_d;
            ovf_q      <= ovf_q | carry_d;
            web_q      <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          if (&addr_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            addr_q     <= addr_q + ADDR_W'(1);
            in_ready_q <= 1'b1;
            state_q    <= FIRST;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign WEB      = web_q;
  assign AddrB    = addr_q;
  assign DataInB  = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_mcb_result_writer.sv
// Scoreboard bench for mcb_result_writer: stimulus pushes expected MC_B
// writes into a queue, an independent monitor pops and compares on WEB.
module tb_mcb_result_writer;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       WEB;
  logic [1:0] AddrB;
  logic [7:0] DataInB;
  logic       busy;
  logic       done;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic web_prev = 1'b0;

  mcb_result_writer #(.DATA_W(8), .ADDR_W(2)) dut (
    .clock   (clock),
    .Reset   (Reset),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .WEB     (WEB),
    .AddrB   (AddrB),
    .DataInB (DataInB),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every MC_B write must match the next queued expectation.
  always @(negedge clock) begin
    if (WEB) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write", AddrB, DataInB);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", int'(AddrB), int'(e.addr));
        chk("write_data", int'(DataInB), int'(e.data));
      end
      chk("in_ready_during_write", int'(in_ready), 0);
      chk("web_not_back_to_back", int'(web_prev), 0);
    end
    web_prev = WEB;
  end

  task automatic push(input logic [1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present a sample and hold it until the DUT accepts it.
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    @(negedge clock);
  endtask

  task automatic wait_done(input logic exp_ovf);
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", int'(done), 1);
    chk("ovf_at_done", int'(ovf), int'(exp_ovf));
    chk("queue_drained", exp_q.size(), 0);
    @(negedge clock);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("ovf_holds_in_done", int'(ovf), int'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    Reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_web", int'(WEB), 0);
    chk("rst_addr", int'(AddrB), 0);
    chk("rst_data", int'(DataInB), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);

    // Full batch 1..8; start coincides with a valid sample that must wait.
    push(2'd0, 8'd3); push(2'd1, 8'd7); push(2'd2, 8'd11); push(2'd3, 8'd15);
    in_valid = 1'b1;
    in_data  = 8'd1;
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    for (int i = 1; i <= 8; i++) send(8'(i));
    in_valid = 1'b0;
    wait_done(1'b0);

    // Compare select, including equality and a large subtraction.
    push(2'd0, 8'd2); push(2'd1, 8'd8); push(2'd2, 8'd0); push(2'd3, 8'd100);
    pulse_start();
    send(8'd5); send(8'd3); send(8'd3); send(8'd5);
    send(8'd9); send(8'd9); send(8'd200); send(8'd100);
    in_valid = 1'b0;
    wait_done(1'b0);

    // Overflow on the first pair; ovf sticky through DONE.
`ifdef MCB_SATURATE_EN
    push(2'd0, 8'd255);
`else
    push(2'd0, 8'd44);
`endif
    push(2'd1, 8'd0); push(2'd2, 8'd0); push(2'd3, 8'd4);
    pulse_start();
    send(8'd100); send(8'd200);
    send(8'd1); send(8'd1); send(8'd0); send(8'd0); send(8'd7); send(8'd3);
    in_valid = 1'b0;
    wait_done(1'b1);
    repeat (2) @(negedge clock);
    chk("ovf_sticky_done", int'(ovf), 1);

    // Stalls: in_valid 1-0-0-1 within a pair; new start clears ovf.
    push(2'd0, 8'd30); push(2'd1, 8'd1); push(2'd2, 8'd3); push(2'd3, 8'd9);
    pulse_start();
    chk("ovf_cleared_by_start", int'(ovf), 0);
    send(8'd10);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    send(8'd20);
    in_valid = 1'b0;
    @(negedge clock);
    send(8'd2); send(8'd1); send(8'd1); send(8'd2); send(8'd4); send(8'd5);
    in_valid = 1'b0;
    wait_done(1'b0);

    // Reset lands on the edge that would accept the second sample.
    pulse_start();
    send(8'd50);
    in_data = 8'd60;
    Reset   = 1'b1;
    @(negedge clock);
    Reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_web", int'(WEB), 0);
    chk("midrst_addr", int'(AddrB), 0);
    chk("midrst_data", int'(DataInB), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(ovf), 0);
    repeat (3) @(negedge clock);
    chk("midrst_stays_idle", int'(busy), 0);

    // Restart after reset, with a spurious start during SECOND.
    push(2'd0, 8'd3); push(2'd1, 8'd7); push(2'd2, 8'd11); push(2'd3, 8'd15);
    pulse_start();
    send(8'd1);
    start = 1'b1;
    send(8'd2);
    start = 1'b0;
    for (int i = 3; i <= 8; i++) send(8'(i));
    in_valid = 1'b0;
    wait_done(1'b0);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
